// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable data memory and its lane alignment logic.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  // Byte-enable for an access of the given size starting at the given lane.
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    byte_enable = 4'b0001 << lane;
      SZ_H:    byte_enable = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    byte_enable = 4'b1111;
      default: byte_enable = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store-data replication and byte enables on the way in,
// lane extraction and sign/zero extension on the way out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign be = byte_enable(size, lane);

  // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wdata_rep = wdata;
    case (size)
      SZ_B:    wdata_rep = {4{wdata[7:0]}};
      SZ_H:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    rdata = word;
    case (size)
      SZ_B:    rdata = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    rdata = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with valid/ready request port, registered one-cycle
// response, access checks and a post-reset sequential clear engine.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter bit          PROT_EN   = 1'b1,
  parameter logic [31:0] PROT_ADDR = 32'h0000_2000,
  parameter logic [31:0] PROT_INIT = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [29:0] PROT_IDX = PROT_ADDR[31:2];
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  state_e          state, state_next;
  logic [AW-1:0]   init_idx;
  logic            init_last;
  logic [31:0]     init_value;

  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic [29:0]     req_idx;
  logic [1:0]      lane;
  logic            req_err;
  logic [31:0]     rd_word;
  logic [31:0]     wdata_rep;
  logic [3:0]      req_be;
  logic [31:0]     load_data;

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [31:0]     wr_data;
  logic [3:0]      wr_be;

  assign req_ready = (state == RUN);
  assign init_done = (state == RUN);
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[31:2];
  assign lane      = req_addr[1:0];
  assign rd_word   = mem[req_idx[AW-1:0]];

  assign init_last  = (init_idx == AW'(DEPTH - 1));
  assign init_value = (PROT_EN && (30'(init_idx) == PROT_IDX)) ? PROT_INIT : 32'h0;

  // Any failed check turns the request into a no-op that only reports rsp_err.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = lane[0];
      SZ_W:    req_err = (lane != 2'b00);
      default: req_err = 1'b1;
    endcase
    if (req_idx >= DEPTH_W)
      req_err = 1'b1;
    if (req_we && PROT_EN && (req_idx == PROT_IDX))
      req_err = 1'b1;
  end

  dmem_lane_align u_lane_align (
    .size        (req_size),
    .lane        (lane),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .word        (rd_word),
    .wdata_rep   (wdata_rep),
    .be          (req_be),
    .rdata       (load_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_last) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state <= state_next;
      if (state == INIT)
        init_idx <= init_idx + 1'b1;
    end
  end

  // Single write port shared by the clear engine and accepted stores.
  always_comb begin
    wr_en   = accept && req_we && !req_err;
    wr_idx  = req_idx[AW-1:0];
    wr_data = wdata_rep;
    wr_be   = req_be;
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx;
      wr_data = init_value;
      wr_be   = 4'hF;
    end
  end

  // NOTE: the array is deliberately left out of reset; the init engine defines its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b])
          mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && req_err;
      rsp_rdata <= (accept && !req_err && !req_we) ? load_data : 32'h0;
    end
  end

endmodule
